receiver: RTL

UART serial receiver with 16x oversampling. It sits at the far end of the serial line, downstream of the transmitter stage, and shares the same tick source and frame configuration (parity enable, stop-bit count). It recovers one BITS_PER_DATA-wide word per frame and signals completion with a one-cycle pulse. Parity and framing errors are flagged on that same pulse.

---
 rtl/receiver_pkg.sv | 17 +
 rtl/sync_2ff.sv | 15 +
 rtl/receiver.sv | 113 +++++++++++
 3 files changed

// File: rtl/receiver_pkg.sv
// receiver_pkg: one-hot UART state encodings, tick default and stop-bit decode shared with the transmitter
package receiver_pkg;
  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    START  = 6'b000010,
    DATA   = 6'b000100,
    PARITY = 6'b001000,
    STOP   = 6'b010000,
    RESET  = 6'b100000
  } state_t;
  localparam int NUM_TICKS_DEF = 16;
  localparam logic [1:0] STOP2_A = 2'b10;
  localparam logic [1:0] STOP2_B = 2'b11;
  function automatic logic two_stops(input logic [1:0] sb);
    return (sb == STOP2_A) || (sb == STOP2_B);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit with a configurable reset value
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk) begin
    if (reset) {q, m} <= {2{RST_VAL}};
    else {q, m} <= {m, d};
  end
endmodule

// File: rtl/receiver.sv
// receiver: 16x-oversampled UART receiver with optional even parity and 1/2 stop bits
module receiver
  import receiver_pkg::*;
#(
  parameter int NUM_TICKS = NUM_TICKS_DEF,
  parameter int BITS_PER_DATA = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     rx_in,
  input  logic                     parity,
  input  logic [1:0]               stop_bits,
  output logic [BITS_PER_DATA-1:0] d_out,
  output logic                     rx_done,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic [5:0]               debug
);
  localparam int SW = $clog2(NUM_TICKS);
  localparam int NW = $clog2(BITS_PER_DATA + 1);
  localparam logic [SW-1:0] HALF = SW'(NUM_TICKS / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(NUM_TICKS - 1);
  localparam logic [NW-1:0] NLAST = NW'(BITS_PER_DATA - 1);
  state_t state, state_n;
  logic [SW-1:0] s, s_n;
  logic [NW-1:0] n, n_n;
  logic [BITS_PER_DATA-1:0] buffer, buf_n, d_n;
  logic rx_s, par_en, par_en_n, two, two_n, sc, sc_n, fin, fin_n;
  logic par_bad, pb_n, fr_bad, fb_n, done_n, pe_n, fe_n;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .reset(reset), .d(rx_in), .q(rx_s));
  assign debug = state;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      s <= '0;
      n <= '0;
      buffer <= '0;
      {par_en, two, sc, fin, par_bad, fr_bad} <= '0;
      d_out <= '0;
      {rx_done, parity_err, frame_err} <= '0;
    end else begin
      state <= state_n;
      s <= s_n;
      n <= n_n;
      buffer <= buf_n;
      {par_en, two, sc, fin, par_bad, fr_bad} <= {par_en_n, two_n, sc_n, fin_n, pb_n, fb_n};
      d_out <= d_n;
      {rx_done, parity_err, frame_err} <= {done_n, pe_n, fe_n};
    end
  end
  always_comb begin
    state_n = state;
    s_n = s;
    n_n = n;
    buf_n = buffer;
    {par_en_n, two_n, sc_n, fin_n, pb_n, fb_n} = {par_en, two, sc, fin, par_bad, fr_bad};
    d_n = d_out;
    done_n = 1'b0;
    pe_n = parity_err;
    fe_n = frame_err;
    case (state)
      IDLE: if (!rx_s) begin
        state_n = START;
        s_n = '0;
        par_en_n = parity;
        two_n = two_stops(stop_bits);
        {sc_n, fin_n, pb_n, fb_n} = '0;
      end
      START: if (tick) begin
        s_n = (s == HALF) ? '0 : s + 1'b1;
        n_n = (s == HALF) ? '0 : n;
        state_n = (s != HALF) ? START : rx_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        s_n = (s == LAST) ? '0 : s + 1'b1;
        if (s == LAST) begin
          buf_n = {rx_s, buffer[BITS_PER_DATA-1:1]};
          n_n = (n == NLAST) ? n : n + 1'b1;
          state_n = (n != NLAST) ? DATA : par_en ? PARITY : STOP;
        end
      end
      PARITY: if (tick) begin
        s_n = (s == LAST) ? '0 : s + 1'b1;
        pb_n = (s == LAST) ? rx_s ^ (^buffer) : par_bad;
        state_n = (s == LAST) ? STOP : PARITY;
      end
      STOP: if (fin) begin
        d_n = buffer;
        done_n = 1'b1;
        pe_n = par_bad;
        fe_n = fr_bad;
        fin_n = 1'b0;
        state_n = IDLE;
      end else if (tick) begin
        s_n = (s == LAST) ? '0 : s + 1'b1;
        if (s == LAST) begin
          fb_n = fr_bad | ~rx_s;
          fin_n = (sc == two);
          sc_n = 1'b1;
        end
      end
      RESET: begin
        s_n = '0;
        n_n = '0;
        buf_n = '0;
        {par_en_n, two_n, sc_n, fin_n, pb_n, fb_n} = '0;
        state_n = IDLE;
      end
      default: state_n = RESET;
    endcase
  end
endmodule
